// File: rtl/aes_frame_loader.sv
// rtl/aes_frame_loader.sv - byte-serial key/text assembler and launcher for the AES core (option: AES_LOADER_PREFETCH_EN)
module aes_frame_loader #(
    parameter int CORE_LATENCY = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_byte,
    input  logic         in_key_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_key,
    output logic [127:0] out_text,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         err_nokey
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;
    state_t state, state_nxt;

    logic [4:0]   bcnt;
    logic         frame_is_key;
    logic         key_loaded;
    logic         frame_full;
    logic [127:0] asm_key;
    logic [127:0] asm_text;
    logic [7:0]   wcnt;

    logic accept, first_byte, cur_is_key, last_byte, to_key;
    logic frame_done, launch_now, launch_direct;

    // A text-only frame with no stored key is promoted to a key frame on its first byte.
    assign accept        = in_valid & in_ready;
    assign first_byte    = (bcnt == 5'd0);
    assign cur_is_key    = first_byte ? (in_key_sel | ~key_loaded) : frame_is_key;
    assign last_byte     = cur_is_key ? (bcnt == 5'd31) : (bcnt == 5'd15);
    assign to_key        = cur_is_key & ~bcnt[4];
    assign frame_done    = accept & last_byte;
    assign launch_direct = (state == IDLE) & frame_done;
    assign launch_now    = (state == IDLE) & (frame_done | frame_full);

`ifdef AES_LOADER_PREFETCH_EN
    assign in_ready = ~reset & ~frame_full;
`else
    assign in_ready = ~reset & ~frame_full & (state == IDLE);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch_now) state_nxt = LAUNCH;
            LAUNCH:  if (out_ready) state_nxt = WAIT;
            WAIT:    if (wcnt == 8'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == LAUNCH);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt         <= 5'd0;
            frame_is_key <= 1'b0;
            key_loaded   <= 1'b0;
            frame_full   <= 1'b0;
            asm_key      <= '0;
            asm_text     <= '0;
            out_key      <= '0;
            out_text     <= '0;
            wcnt         <= 8'd0;
            err_nokey    <= 1'b0;
        end else begin
            err_nokey <= accept & first_byte & ~in_key_sel & ~key_loaded;

            if (accept) begin
                if (first_byte) frame_is_key <= cur_is_key;
                bcnt <= last_byte ? 5'd0 : bcnt + 5'd1;
                if (to_key) asm_key <= {asm_key[119:0], in_byte};
                else        asm_text <= {asm_text[119:0], in_byte};
                if (last_byte && cur_is_key) key_loaded <= 1'b1;
            end

            // The final byte of a frame always lands in the text group, so bypass it on a direct launch.
            if (launch_now) begin
                out_key    <= asm_key;
                out_text   <= launch_direct ? {asm_text[119:0], in_byte} : asm_text;
                frame_full <= 1'b0;
            end else if (frame_done) begin
                frame_full <= 1'b1;
            end

            if (state == LAUNCH && out_ready) begin
                wcnt <= 8'(CORE_LATENCY - 1);
            end else if (state == WAIT && wcnt != 8'd0) begin
                wcnt <= wcnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_frame_loader.sv
// tb/tb_aes_frame_loader.sv - scoreboard bench for aes_frame_loader
module tb_aes_frame_loader;

`ifdef AES_LOADER_PREFETCH_EN
    localparam int LAT = 24;
`else
    localparam int LAT = 11;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   in_byte = 8'd0;
    logic         in_key_sel = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] out_key;
    logic [127:0] out_text;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         busy;
    logic         err_nokey;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nokey_pulses = 0;
    int launch_cycs[$];
    logic [255:0] sb[$];

    aes_frame_loader #(.CORE_LATENCY(LAT)) dut (
        .clk(clk),
        .reset(reset),
        .in_byte(in_byte),
        .in_key_sel(in_key_sel),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_key(out_key),
        .out_text(out_text),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .err_nokey(err_nokey)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] seq16(input logic [7:0] base);
        logic [127:0] w;
        for (int i = 0; i < 16; i++) w[127 - 8*i -: 8] = base + 8'(i);
        return w;
    endfunction

    always @(negedge clk) begin
        logic [255:0] exp_w;
        if (err_nokey) nokey_pulses++;
        if (!reset && out_valid && out_ready) begin
            launch_cycs.push_back(cyc);
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 128'(out_valid), 128'd0);
            end else begin
                exp_w = sb.pop_front();
                check_eq("out_key", out_key, exp_w[255:128]);
                check_eq("out_text", out_text, exp_w[127:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic sel);
        int t;
        in_byte = b;
        in_key_sel = sel;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) check_eq("send_timeout", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input int n, input logic sel);
        for (int i = 0; i < n; i++) send_byte(base + 8'(i), sel);
    endtask

    task automatic finish_launch(input string tag);
        int n;
        @(negedge clk);
        check_eq({tag, "_valid"}, 128'(out_valid), 128'd1);
        check_eq({tag, "_busy"}, 128'(busy), 128'd1);
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_eq({tag, "_busy_len"}, 128'(n), 128'(LAT));
        check_eq({tag, "_sb_drain"}, 128'(sb.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 128'(in_ready), 128'd0);
        check_eq("rst_out_valid", 128'(out_valid), 128'd0);
        check_eq("rst_busy", 128'(busy), 128'd0);
        check_eq("rst_err_nokey", 128'(err_nokey), 128'd0);
        check_eq("rst_out_key", out_key, 128'd0);
        check_eq("rst_out_text", out_text, 128'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;

        sb.push_back({seq16(8'h00), seq16(8'h10)});
        send_frame(8'h00, 32, 1'b1);
        finish_launch("keyframe");

        sb.push_back({seq16(8'h00), seq16(8'hA0)});
        send_frame(8'hA0, 16, 1'b0);
        finish_launch("textframe");
        check_eq("text_nokey_cnt", 128'(nokey_pulses), 128'd0);

        do_reset(2);
        sb.push_back({seq16(8'h40), seq16(8'h50)});
        send_frame(8'h40, 32, 1'b0);
        finish_launch("nokey");
        check_eq("nokey_cnt", 128'(nokey_pulses), 128'd1);

        out_ready = 1'b0;
        sb.push_back({seq16(8'h40), seq16(8'hB0)});
        send_frame(8'hB0, 16, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_valid", 128'(out_valid), 128'd1);
            check_eq("bp_key", out_key, seq16(8'h40));
            check_eq("bp_text", out_text, seq16(8'hB0));
`ifndef AES_LOADER_PREFETCH_EN
            check_eq("bp_in_ready", 128'(in_ready), 128'd0);
`endif
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        finish_launch("bp");

        send_frame(8'hEE, 7, 1'b1);
        do_reset(2);
        sb.push_back({seq16(8'h60), seq16(8'h70)});
        send_frame(8'h60, 32, 1'b1);
        finish_launch("midreset");

`ifdef AES_LOADER_PREFETCH_EN
        begin
            int t;
            launch_cycs.delete();
            sb.push_back({seq16(8'h80), seq16(8'h90)});
            sb.push_back({seq16(8'h80), seq16(8'hC0)});
            send_frame(8'h80, 32, 1'b1);
            send_frame(8'hC0, 16, 1'b0);
            @(negedge clk);
            check_eq("pf_in_ready", 128'(in_ready), 128'd0);
            t = 0;
            while (launch_cycs.size() < 2 && t < 200) begin
                @(posedge clk);
                t++;
            end
            check_eq("pf_launches", 128'(launch_cycs.size()), 128'd2);
            if (launch_cycs.size() == 2)
                check_eq("pf_gap", 128'(launch_cycs[1] - launch_cycs[0]), 128'(LAT + 2));
            t = 0;
            @(negedge clk);
            while (busy && t < 200) begin
                t++;
                @(negedge clk);
            end
            check_eq("pf_sb_drain", 128'(sb.size()), 128'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_frame_loader.md
# aes_frame_loader

Byte-serial front end for the iterative AES encryption core. Accepts key and plaintext bytes over a valid/ready stream and assembles them into 128-bit words. Presents the words to the core through a valid/ready launch handshake, then holds off the next launch until the core's fixed round latency has elapsed. Sits directly upstream of the encryption core: `out_key` drives its secret-key input and `out_text` drives its plaintext input.

## Interface
- `CORE_LATENCY`, default 11: cycles the core needs after a launch (initial AddRoundKey plus 10 rounds); legal range 1..255.
- `clk`  in  1  single clock; everything is sampled on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_byte`  in  8  stream data byte.
- `in_key_sel`  in  1  sampled only on the first byte of a frame: 1 = 32-byte frame (16 key bytes, then 16 text bytes); 0 = 16-byte text frame that reuses the stored key.
- `in_valid`  in  1  byte present.
- `in_ready`  out  1  loader accepts a byte; a transfer happens when `in_valid & in_ready`.
- `out_key`  out  128  key word presented to the core.
- `out_text`  out  128  plaintext word presented to the core.
- `out_valid`  out  1  launch request.
- `out_ready`  in  1  core accepts the launch.
- `busy`  out  1  launcher is not in IDLE.
- `err_nokey`  out  1  one-cycle pulse: a text-only frame was started while no key had been loaded.

## Operation
- Assembler: byte counter `bcnt` (0..31), frame-type flag, 128-bit shift registers `asm_key` and `asm_text`, and a `frame_full` flag.
- Byte order: the first byte of each 16-byte group lands in bits [127:120]; the 16th byte lands in [7:0]. Each group shifts in left by 8 bits.
- Key frame: bytes 0–15 go to `asm_key`, bytes 16–31 go to `asm_text`. On completion, `key_loaded` is set to 1.
- Text frame: bytes 0–15 go to `asm_text`; `asm_key` is kept unchanged.
- Missing key: if the first byte of a frame arrives with `in_key_sel=0` while `key_loaded=0`, the frame is forced to a key frame and `err_nokey` pulses in the next cycle.
- Launcher FSM states: IDLE, LAUNCH, WAIT.
  - IDLE → LAUNCH: a frame completes, or `frame_full` is set. On this edge, `out_key`/`out_text` load from the assembly registers and `frame_full` clears.
  - LAUNCH: `out_valid=1`. On `out_ready`, go to WAIT and load `wcnt` with CORE_LATENCY−1.
  - WAIT: decrement `wcnt`; when `wcnt==0`, go to IDLE.
- `out_key`/`out_text` change only on the IDLE→LAUNCH edge. They are stable through LAUNCH and WAIT.
- A frame that completes while the launcher is not in IDLE sets `frame_full`.
- `in_ready` (without the macro) = `!reset & !frame_full & (state==IDLE)`.
- `busy` = (state != IDLE).

## Timing
- Reset values: `in_ready=0` while `reset` is high, `out_valid=0`, `busy=0`, `err_nokey=0`, `out_key=0`, `out_text=0`. Also `key_loaded=0`, `bcnt=0`, `frame_full=0`, state=IDLE.
- `in_ready=1` in the first cycle after `reset` deasserts.
- Latency: last byte accepted in cycle T with the launcher in IDLE → `out_valid=1` at T+1.
- Launch accepted in cycle L → `busy` high in L+1..L+CORE_LATENCY. IDLE and `busy=0` at L+CORE_LATENCY+1.
- `out_valid` holds, with its data stable, for any number of cycles that `out_ready` stays low.
- `out_ready` is ignored outside LAUNCH.
- `in_byte`/`in_key_sel` are ignored when `in_valid=0` or `in_ready=0`.
- `reset` mid-frame or mid-WAIT discards the partial frame and pending launch, clears `key_loaded`, and returns all state to its reset values.
- `bcnt` wraps to 0 after the last byte of a frame (byte 15 or byte 31).

## Configuration
- `AES_LOADER_PREFETCH_EN` defined:
  - `in_ready` = `!reset & !frame_full`, so the next frame assembles during LAUNCH and WAIT.
  - The completed frame waits in `frame_full`; IDLE with `frame_full` → LAUNCH on the next edge, so `out_valid` rises one cycle after returning to IDLE.
  - The assembly registers are separate from the out registers, so prefetch never disturbs the launched words.
- Not defined: `in_ready` is low whenever the launcher is not in IDLE, and `frame_full` can never be set.

## Test plan
- Key frame: `in_key_sel=1`, bytes 0x00..0x1F back-to-back, `out_ready=1` → `out_key=0x000102..0F`, `out_text=0x101112..1F`, `out_valid` for one cycle at T+1, `busy` for 11 cycles, then IDLE.
- Text frame after a key frame: `in_key_sel=0`, bytes 0xA0..0xAF → `out_key` unchanged, `out_text=0xA0A1..AF`, `err_nokey=0`.
- Text frame right after reset: `in_key_sel=0`, 32 bytes → `err_nokey` pulses once after byte 0, and the frame is treated as a key frame.
- Backpressure: `out_ready=0` for 5 cycles → `out_valid`, `out_key`, `out_text` stable, `in_ready=0`; launch completes in the cycle `out_ready` rises.
- Reset after 7 bytes, then a full key frame → output contains only the new bytes; `bcnt` restarted from 0.
- With `AES_LOADER_PREFETCH_EN`: second text frame streamed during WAIT → `in_ready` drops after its 16th byte; second `out_valid` at L+CORE_LATENCY+2 with the new text.
